// File: rtl/friscv_apb_master_pkg.sv
// Shared types and constants for the APB-like bus initiator.
package friscv_h;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 1024;

  localparam logic ERR_NONE    = 1'b0;
  localparam logic ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/friscv_apb_master_if.sv
// Request/response channels and slave-side bus of the APB-like initiator.
interface friscv_apb_master_if #(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
);

  logic                req_valid;
  logic                req_ready;
  logic                req_wr;
  logic [ADDRW-1:0]    req_addr;
  logic [XLEN-1:0]     req_wdata;
  logic [XLEN/8-1:0]   req_strb;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [XLEN-1:0]     rsp_rdata;
  logic                rsp_err;

  logic                mst_en;
  logic                mst_wr;
  logic [ADDRW-1:0]    mst_addr;
  logic [XLEN-1:0]     mst_wdata;
  logic [XLEN/8-1:0]   mst_strb;
  logic [XLEN-1:0]     mst_rdata;
  logic                mst_ready;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output mst_en, mst_wr, mst_addr, mst_wdata, mst_strb,
    input  mst_rdata, mst_ready
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  mst_en, mst_wr, mst_addr, mst_wdata, mst_strb,
    output mst_rdata, mst_ready
  );

endinterface

// File: rtl/friscv_apb_master.sv
// Single-outstanding APB-like bus initiator with a per-transfer ready timeout.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready=1
// ACCESS | mst_en=1, waiting for the slave's ready pulse or timeout
// RESP   | response held on the rsp channel until consumed
module friscv_apb_master
  import friscv_h::*;
#(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                aclk,
  input  logic                srst,
  friscv_apb_master_if.master bus
);

  localparam int STRBW = XLEN / 8;
  localparam int CNTW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  state_t             state,     state_nxt;
  logic               en_q,      en_d;
  logic               wr_q,      wr_d;
  logic [ADDRW-1:0]   addr_q,    addr_d;
  logic [XLEN-1:0]    wdata_q,   wdata_d;
  logic [STRBW-1:0]   strb_q,    strb_d;
  logic               rvalid_q,  rvalid_d;
  logic [XLEN-1:0]    rdata_q,   rdata_d;
  logic               err_q,     err_d;
  logic [CNTW-1:0]    cnt_q,     cnt_d;
  logic               timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge aclk) begin
    if (srst) begin
      state    <= IDLE;
      en_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= ERR_NONE;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      en_q     <= en_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_nxt = state;
    en_d      = en_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          en_d      = 1'b1;
          wr_d      = bus.req_wr;
          addr_d    = bus.req_addr;
          wdata_d   = bus.req_wdata;
          strb_d    = bus.req_wr ? bus.req_strb : '0;
          cnt_d     = '0;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // A ready landing on the expiry cycle still completes normally.
        if (bus.mst_ready) begin
          en_d      = 1'b0;
          rdata_d   = wr_q ? '0 : bus.mst_rdata;
          err_d     = ERR_NONE;
          rvalid_d  = 1'b1;
          state_nxt = RESP;
        end else if (timeout_hit) begin
          en_d      = 1'b0;
          rdata_d   = '0;
          err_d     = ERR_TIMEOUT;
          rvalid_d  = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rvalid_d  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rvalid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mst_en    = en_q;
  assign bus.mst_wr    = wr_q;
  assign bus.mst_addr  = addr_q;
  assign bus.mst_wdata = wdata_q;
  assign bus.mst_strb  = strb_q;

endmodule

// File: tb/tb_friscv_apb_master.sv
// Self-checking bench: configurable-latency slave plus an outcome model per transfer.
module tb_friscv_apb_master;

  localparam int ADDRW = 16;
  localparam int XLEN  = 32;
  localparam int TMO   = 8;

  typedef struct {
    logic        accepted;
    int          en_cnt;
    int          rsp_cyc;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        stable;
    logic        hold_ok;
    logic        consumed;
  } obs_t;

  logic aclk = 1'b0;
  logic srst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          slave_lat    = 1;
  logic [31:0] slave_data   = 32'h0;
  logic        inject_ready = 1'b0;
  int          en_age       = 0;

  friscv_apb_master_if #(.ADDRW(ADDRW), .XLEN(XLEN)) bus ();

  friscv_apb_master #(.ADDRW(ADDRW), .XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .aclk (aclk),
    .srst (srst),
    .bus  (bus)
  );

  always #5 aclk = ~aclk;

  // Slave: pulses ready slave_lat cycles after en rises (0 = never answers).
  initial begin
    bus.mst_ready = 1'b0;
    bus.mst_rdata = '0;
    forever begin
      @(posedge aclk);
      #1;
      en_age        = bus.mst_en ? en_age + 1 : 0;
      bus.mst_ready = inject_ready || (slave_lat != 0 && en_age == slave_lat + 1);
      bus.mst_rdata = bus.mst_ready ? slave_data : $urandom;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Outcome of one transfer: the slave's ready counts only if it arrives
  // within TMO cycles of en rising.
  function automatic void model(input logic wr, input int lat, input logic [31:0] data,
                                output int exp_en, output logic [31:0] exp_rdata,
                                output logic exp_err);
    exp_err   = (lat == 0) || (lat > TMO - 1);
    exp_en    = exp_err ? TMO : lat + 1;
    exp_rdata = (exp_err || wr) ? 32'h0 : data;
  endfunction

  // Drives one request from a negedge with the DUT idle; returns observations only.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int lat, input logic [31:0] data,
                         input int hold, output obs_t o);
    logic first;
    slave_lat     = lat;
    slave_data    = data;
    bus.rsp_ready = (hold == 0);
    o.accepted    = bus.req_ready;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    @(posedge aclk);
    @(negedge aclk);
    bus.req_valid = 1'b0;
    bus.req_wr    = ~wr;
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = $urandom;
    bus.req_strb  = 4'($urandom);
    o.en_cnt  = 0;
    o.rsp_cyc = -1;
    o.stable  = 1'b1;
    o.addr = '0; o.wr = 1'b0; o.wdata = '0; o.strb = '0;
    first = 1'b1;
    for (int c = 1; c <= TMO + 6; c++) begin
      if (bus.mst_en) begin
        if (first) begin
          o.addr = bus.mst_addr; o.wr = bus.mst_wr;
          o.wdata = bus.mst_wdata; o.strb = bus.mst_strb;
          first = 1'b0;
        end else if (o.addr !== bus.mst_addr || o.wr !== bus.mst_wr ||
                     o.wdata !== bus.mst_wdata || o.strb !== bus.mst_strb) begin
          o.stable = 1'b0;
        end
        o.en_cnt++;
      end
      if (bus.rsp_valid) begin
        o.rsp_cyc = c;
        break;
      end
      @(negedge aclk);
    end
    o.rdata   = bus.rsp_rdata;
    o.err     = bus.rsp_err;
    o.hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      if (!bus.rsp_valid || bus.rsp_rdata !== o.rdata || bus.rsp_err !== o.err ||
          bus.req_ready || bus.mst_en)
        o.hold_ok = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    o.consumed = !bus.rsp_valid && bus.req_ready;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    n_tests++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_tests++;
    if ({bus.mst_en, bus.mst_wr, bus.mst_addr, bus.mst_wdata, bus.mst_strb} !== '0) begin
      n_fail++; $display("FAIL reset_mst: en=%b wr=%b addr=%h wdata=%h strb=%h want all 0",
                         bus.mst_en, bus.mst_wr, bus.mst_addr, bus.mst_wdata, bus.mst_strb);
    end
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rsp: valid=%b err=%b rdata=%h want all 0",
                         bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    srst = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_write_single();
    obs_t o; int ee; logic [31:0] er; logic eerr;
    model(1'b1, 1, 32'h1357_9BDF, ee, er, eerr);
    run_txn(1'b1, 16'h0000, 32'hA5A5_1234, 4'hF, 1, 32'h1357_9BDF, 0, o);
    n_tests++;
    if (o.accepted !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got %b want 1", o.accepted); end
    n_tests++;
    if (o.en_cnt !== 2 || o.en_cnt !== ee) begin n_fail++; $display("FAIL wr_en_cycles: got %0d want 2", o.en_cnt); end
    n_tests++;
    if (o.rsp_cyc !== 3) begin n_fail++; $display("FAIL wr_rsp_latency: got %0d want 3", o.rsp_cyc); end
    n_tests++;
    if ({o.addr, o.wr, o.wdata, o.strb} !== {16'h0000, 1'b1, 32'hA5A5_1234, 4'hF} || !o.stable) begin
      n_fail++; $display("FAIL wr_bus: addr=%h wr=%b wdata=%h strb=%h stable=%b want 0000/1/a5a51234/f/1",
                         o.addr, o.wr, o.wdata, o.strb, o.stable);
    end
    n_tests++;
    if (o.rdata !== er || o.err !== eerr) begin
      n_fail++; $display("FAIL wr_rsp: rdata=%h err=%b want %h/%b", o.rdata, o.err, er, eerr);
    end
    n_tests++;
    if (!o.consumed) begin n_fail++; $display("FAIL wr_consumed: got 0 want 1"); end
  endtask

  task automatic test_read();
    obs_t o;
    run_txn(1'b0, 16'h0001, 32'h5555_AAAA, 4'hF, 1, 32'hDEAD_BEEF, 0, o);
    n_tests++;
    if (o.strb !== 4'h0 || o.wr !== 1'b0 || o.addr !== 16'h0001) begin
      n_fail++; $display("FAIL rd_bus: strb=%h wr=%b addr=%h want 0/0/0001", o.strb, o.wr, o.addr);
    end
    n_tests++;
    if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp: rdata=%h err=%b want deadbeef/0", o.rdata, o.err);
    end
  endtask

  task automatic test_timeout();
    obs_t o; logic late_seen;
    run_txn(1'b0, 16'h0040, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 0, o);
    n_tests++;
    if (o.en_cnt !== TMO) begin n_fail++; $display("FAIL tmo_en_cycles: got %0d want %0d", o.en_cnt, TMO); end
    n_tests++;
    if (o.rsp_cyc !== TMO + 1) begin n_fail++; $display("FAIL tmo_rsp_latency: got %0d want %0d", o.rsp_cyc, TMO + 1); end
    n_tests++;
    if (o.err !== 1'b1 || o.rdata !== 32'h0) begin
      n_fail++; $display("FAIL tmo_rsp: err=%b rdata=%h want 1/0", o.err, o.rdata);
    end
    inject_ready = 1'b1;
    @(negedge aclk);
    inject_ready = 1'b0;
    late_seen = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      if (bus.rsp_valid || bus.mst_en) late_seen = 1'b1;
    end
    n_tests++;
    if (late_seen !== 1'b0) begin n_fail++; $display("FAIL tmo_late_ready: got response/en want none"); end
  endtask

  task automatic test_timeout_boundary();
    obs_t o;
    run_txn(1'b0, 16'h0077, 32'h0, 4'h0, TMO - 1, 32'h0BAD_CAFE, 0, o);
    n_tests++;
    if (o.err !== 1'b0 || o.rdata !== 32'h0BAD_CAFE || o.en_cnt !== TMO) begin
      n_fail++; $display("FAIL bnd_last_cycle_ready: err=%b rdata=%h en=%0d want 0/0badcafe/%0d",
                         o.err, o.rdata, o.en_cnt, TMO);
    end
    run_txn(1'b0, 16'h0078, 32'h0, 4'h0, TMO, 32'h0BAD_CAFE, 0, o);
    n_tests++;
    if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.en_cnt !== TMO) begin
      n_fail++; $display("FAIL bnd_one_late: err=%b rdata=%h en=%0d want 1/0/%0d", o.err, o.rdata, o.en_cnt, TMO);
    end
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_txn(1'b0, 16'h1234, 32'h0, 4'h0, 2, 32'h8765_4321, 5, o);
    n_tests++;
    if (o.hold_ok !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got unstable want stable"); end
    n_tests++;
    if (o.rdata !== 32'h8765_4321 || o.err !== 1'b0) begin
      n_fail++; $display("FAIL bp_rsp: rdata=%h err=%b want 87654321/0", o.rdata, o.err);
    end
    n_tests++;
    if (o.consumed !== 1'b1) begin n_fail++; $display("FAIL bp_consumed: got 0 want 1"); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [3];
    logic [15:0] rise_addr [3];
    int   en_rise [3];
    int   n_rise = 0, n_rsp = 0, min_gap = 1000, low_run = 0, idx = 0;
    logic prev_en = 1'b0, hs;
    for (int k = 0; k < 3; k++) begin
      addrs[k] = 16'($urandom); en_rise[k] = -100; rise_addr[k] = '0;
    end
    slave_lat     = 1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = addrs[0];
    bus.req_wdata = $urandom;
    bus.req_strb  = 4'hF;
    for (int c = 0; c < 20; c++) begin
      hs = bus.req_valid && bus.req_ready;
      if (bus.mst_en && !prev_en) begin
        if (n_rise < 3) begin en_rise[n_rise] = c; rise_addr[n_rise] = bus.mst_addr; end
        n_rise++;
        if (n_rise > 1 && low_run < min_gap) min_gap = low_run;
      end
      low_run = bus.mst_en ? 0 : low_run + 1;
      if (bus.rsp_valid) n_rsp++;
      prev_en = bus.mst_en;
      @(posedge aclk);
      @(negedge aclk);
      if (hs) begin
        idx++;
        if (idx < 3) begin bus.req_addr = addrs[idx]; bus.req_wdata = $urandom; end
        else bus.req_valid = 1'b0;
      end
    end
    n_tests++;
    if (n_rsp !== 3 || n_rise !== 3) begin
      n_fail++; $display("FAIL b2b_count: rsp=%0d en_rises=%0d want 3/3", n_rsp, n_rise);
    end
    n_tests++;
    if (en_rise[0] !== 1 || en_rise[1] - en_rise[0] !== 4 || en_rise[2] - en_rise[1] !== 4) begin
      n_fail++; $display("FAIL b2b_period: rises=%0d,%0d,%0d want 1,5,9", en_rise[0], en_rise[1], en_rise[2]);
    end
    n_tests++;
    if (min_gap < 2) begin n_fail++; $display("FAIL b2b_gap: got %0d want >=2", min_gap); end
    n_tests++;
    if (rise_addr[0] !== addrs[0] || rise_addr[1] !== addrs[1] || rise_addr[2] !== addrs[2]) begin
      n_fail++; $display("FAIL b2b_addr: got %h %h %h want %h %h %h", rise_addr[0], rise_addr[1],
                         rise_addr[2], addrs[0], addrs[1], addrs[2]);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    slave_lat     = 0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 16'h0BEE;
    bus.req_wdata = 32'h1111_2222;
    bus.req_strb  = 4'h3;
    @(posedge aclk);
    @(negedge aclk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge aclk);
    n_tests++;
    if (bus.mst_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_en: got %b want 1", bus.mst_en); end
    srst = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    n_tests++;
    if (bus.mst_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_state: en=%b rsp_valid=%b req_ready=%b want 0/0/1",
                         bus.mst_en, bus.rsp_valid, bus.req_ready);
    end
    srst = 1'b0;
    @(negedge aclk);
    run_txn(1'b0, 16'h0C00, 32'h0, 4'hF, 2, 32'h600D_DA7A, 0, o);
    n_tests++;
    if (o.rdata !== 32'h600D_DA7A || o.err !== 1'b0 || o.en_cnt !== 3 || o.rsp_cyc !== 4) begin
      n_fail++; $display("FAIL rst_mid_after_read: rdata=%h err=%b en=%0d lat=%0d want 600dda7a/0/3/4",
                         o.rdata, o.err, o.en_cnt, o.rsp_cyc);
    end
  endtask

  task automatic test_random();
    obs_t o; int ee; logic [31:0] er; logic eerr;
    logic wr; logic [15:0] a; logic [31:0] wd, d; logic [3:0] s; int lat, hold;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); a = 16'($urandom); wd = $urandom; d = $urandom; s = 4'($urandom);
      lat = $urandom_range(0, TMO + 2); hold = $urandom_range(0, 3);
      model(wr, lat, d, ee, er, eerr);
      run_txn(wr, a, wd, s, lat, d, hold, o);
      n_tests++;
      if (o.accepted !== 1'b1 || o.en_cnt !== ee || o.rsp_cyc !== ee + 1) begin
        n_fail++; $display("FAIL rnd%0d_timing: acc=%b en=%0d lat=%0d want 1/%0d/%0d",
                           i, o.accepted, o.en_cnt, o.rsp_cyc, ee, ee + 1);
      end
      n_tests++;
      if ({o.addr, o.wr, o.wdata, o.strb} !== {a, wr, wd, wr ? s : 4'h0} || !o.stable) begin
        n_fail++; $display("FAIL rnd%0d_bus: addr=%h wr=%b wdata=%h strb=%h stable=%b want %h/%b/%h/%h/1",
                           i, o.addr, o.wr, o.wdata, o.strb, o.stable, a, wr, wd, wr ? s : 4'h0);
      end
      n_tests++;
      if (o.rdata !== er || o.err !== eerr || !o.hold_ok || !o.consumed) begin
        n_fail++; $display("FAIL rnd%0d_rsp: rdata=%h err=%b hold=%b done=%b want %h/%b/1/1",
                           i, o.rdata, o.err, o.hold_ok, o.consumed, er, eerr);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_single();
    test_read();
    test_timeout();
    test_timeout_boundary();
    test_backpressure();
    test_back_to_back();
    repeat (2) @(negedge aclk);
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/friscv_apb_master.md
Name: friscv_apb_master

Overview:
- Initiator side of the team's APB-like peripheral bus: slave-side signals en/wr/addr/wdata/strb/rdata/ready.
- Accepts single load/store requests from the core's data path over a valid/ready request channel.
- Drives one bus transfer at a time and waits for the slave's ready pulse.
- Returns read data, or a timeout error, on a valid/ready response channel.
- Sits between the core's memory stage and the peripheral slaves (GPIOs, UART, timers).

Parameters:
- ADDRW, 16, bus address width.
- XLEN, 32, data width; strobe width is XLEN/8.
- TIMEOUT, 1024, max cycles in ACCESS before error; 0 disables the timeout.

Ports:
- aclk  in  1  clock
- srst  in  1  reset, synchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDRW  request address
- req_wdata  in  XLEN  write data
- req_strb  in  XLEN/8  byte strobes (write only)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  XLEN  read data; 0 for writes and errors
- rsp_err  out  1  1 = timeout, no slave ready seen
- mst_en  out  1  bus transfer enable
- mst_wr  out  1  bus write
- mst_addr  out  ADDRW  bus address
- mst_wdata  out  XLEN  bus write data
- mst_strb  out  XLEN/8  bus strobes
- mst_rdata  in  XLEN  slave read data, valid while mst_ready=1
- mst_ready  in  1  slave completion pulse

Behaviour:
- Clock and reset: single clock aclk; reset is srst, synchronous, active-high. All state is registered on aclk.
- Reset values: state=IDLE, mst_en=0, mst_wr=0, mst_addr=0, mst_wdata=0, mst_strb=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
- req_ready is decoded from the state register only: 1 iff state==IDLE. It does not depend on req_valid.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on req_valid:
  - Latch wr/addr/wdata/strb onto the mst_* registers and set mst_en=1.
  - Clear the counter; go to ACCESS.
  - On a read, mst_strb is driven as all zeros.
- ACCESS, mst_ready=1 sampled:
  - Set mst_en=0.
  - rsp_rdata = mst_rdata for a read, 0 for a write.
  - rsp_err=0, rsp_valid=1; go to RESP.
- ACCESS, no mst_ready and TIMEOUT!=0 and counter==TIMEOUT-1:
  - Set mst_en=0, rsp_rdata=0, rsp_err=1, rsp_valid=1; go to RESP.
  - Otherwise increment the counter. Counter width is $clog2(TIMEOUT+1).
- ACCESS, simultaneous: if mst_ready and timeout expiry land in the same cycle, mst_ready wins and rsp_err=0.
- Bus stability: mst_addr, mst_wr, mst_wdata and mst_strb are stable for the whole of ACCESS.
- RESP: rsp_valid, rsp_rdata and rsp_err hold until rsp_ready. On rsp_ready, set rsp_valid=0 and go to IDLE.
- mst_ready outside ACCESS is ignored, including a late ready after a timeout. No response is generated for it.
- Gap between transfers: mst_en is low for at least 2 cycles (the RESP and IDLE cycles). This guarantees the slave's ready pulse has cleared before the next transfer.
- Latency against a slave that returns ready one cycle after en:
  - Cycle 0: request handshake.
  - Cycle 1: mst_en=1.
  - Cycle 2: mst_ready=1.
  - Cycle 3: rsp_valid=1.
  - Minimum request-to-request period is 4 cycles with rsp_ready tied to 1.
- srst mid-operation: next edge returns to IDLE, drops mst_en, and discards any pending response.

Decomposition:
- Shared package friscv_h holds:
  - State enum typedef (IDLE/ACCESS/RESP).
  - Default TIMEOUT constant.
  - rsp_err encoding constant.
- Flat module; no sub-module is needed. The timeout counter stays inline, as it is under 10 lines.

Test Plan:
- Write, single cycle: req wr=1, addr=0x0000, wdata=0xA5A5_1234, strb=0xF. Required: mst_en high for exactly 2 cycles with those values; rsp_valid at cycle 3 with rdata=0, err=0.
- Read with a slave model returning 0xDEAD_BEEF: req wr=0, addr=0x0001. Required: mst_strb=0, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Timeout: TIMEOUT=8, slave never asserts ready. Required: mst_en high for 8 cycles then low; rsp_err=1, rsp_rdata=0. A late mst_ready 2 cycles later produces no second response.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. Required: rsp fields stable, req_ready=0, mst_en=0 throughout. Response completes on the cycle rsp_ready rises.
- Back-to-back: 3 writes with req_valid held high and rsp_ready=1. Required: 3 responses; transfers 4 cycles apart; mst_en low for at least 2 cycles between transfers.
- Reset mid-ACCESS: assert srst during mst_en=1. Required: next edge has mst_en=0, rsp_valid=0, req_ready=1; the following read completes normally.
